// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared constants and helpers for the shared-adder arbiter
package adder_share_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NREQ  = 4;

  // Never return 0, so a 2-requester build still gets a 1-bit ID.
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int rr_index(input int start, input int offset, input int n);
    return (start + offset) % n;
  endfunction

  localparam int RR_PTR_W = idw(DEFAULT_NREQ);
  typedef logic [RR_PTR_W-1:0] rr_ptr_t;

endpackage

// File: rtl/adder_share_arbiter_rr.sv
// rtl/adder_share_arbiter_rr.sv - combinational round-robin grant starting at ptr
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter  int NREQ = DEFAULT_NREQ,
  localparam int IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] idx;
  logic           found;

  // Scan ptr, ptr+1, ... wrapping; the first asserted request wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'(rr_index(int'(ptr), k, NREQ));
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - one registered WIDTH-bit adder shared round-robin by NREQ requesters
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int NREQ  = DEFAULT_NREQ,
  localparam int IDW   = idw(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  input  logic                  rsp_ready
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [IDW-1:0]   ptr_q,       ptr_d;

  logic             can_accept;
  logic             arb_en;
  logic             grant;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic [WIDTH:0]   sum_w;

  // Accept whenever the output slot is empty or being drained this cycle.
  assign can_accept = !rsp_valid_q || rsp_ready;
  assign arb_en     = can_accept && rst_n;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign grant     = |gnt;

  assign a_w   = req_a[gnt_id*WIDTH +: WIDTH];
  assign b_w   = req_b[gnt_id*WIDTH +: WIDTH];
  assign sum_w = {1'b0, a_w} + {1'b0, b_w};

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    ptr_d       = ptr_q;
    if (grant) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_id;
      rsp_sum_d   = sum_w[WIDTH-1:0];
      rsp_carry_d = sum_w[WIDTH];
      ptr_d       = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_carry;
  logic        rsp_ready;

  int checks = 0;
  int errors = 0;

  bit m_valid = 1'b0;
  int m_id    = 0;
  int m_sum   = 0;
  int m_carry = 0;
  int m_ptr   = 0;

  adder_share_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [3:0] v, input int p, input bit en);
    int idx;
    if (!en) return -1;
    for (int k = 0; k < 4; k++) begin
      idx = (p + k) % 4;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    if (!rst_n) return 4'b0000;
    w = rr_pick(req_valid, m_ptr, !m_valid || rsp_ready);
    if (w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  task automatic model_update();
    int w;
    int s;
    if (!rst_n) begin
      m_valid = 1'b0; m_id = 0; m_sum = 0; m_carry = 0; m_ptr = 0;
    end else begin
      w = rr_pick(req_valid, m_ptr, !m_valid || rsp_ready);
      if (w >= 0) begin
        s       = int'(req_a[w*8 +: 8]) + int'(req_b[w*8 +: 8]);
        m_sum   = s % 256;
        m_carry = (s >= 256) ? 1 : 0;
        m_id    = w;
        m_valid = 1'b1;
        m_ptr   = (w + 1) % 4;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_sum !== 8'h00) begin errors++; $display("FAIL reset_rsp_sum: got %h expected 00", rsp_sum); end
    checks++; if (rsp_id !== 2'd0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_id_carry: got %0d/%b expected 0/0", rsp_id, rsp_carry); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_single();
    set_op(2, 8'h12, 8'h34);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'h0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp: got v=%b id=%0d expected v=1 id=2", rsp_valid, rsp_id); end
    checks++; if (rsp_sum !== 8'h46 || rsp_carry !== 1'b0) begin errors++; $display("FAIL single_sum: got %h c=%b expected 46 c=0", rsp_sum, rsp_carry); end
    tick();
  endtask

  task automatic test_overflow();
    set_op(1, 8'hF0, 8'h20);
    req_valid = 4'b0010;
    tick();
    set_op(3, 8'hFF, 8'h01);
    req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (rsp_sum !== 8'h10 || rsp_carry !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL overflow_f0_20: got %h c=%b id=%0d expected 10 c=1 id=1", rsp_sum, rsp_carry, rsp_id); end
    tick();
    req_valid = 4'h0;
    @(negedge clk);
    checks++; if (rsp_sum !== 8'h00 || rsp_carry !== 1'b1 || rsp_id !== 2'd3) begin errors++; $display("FAIL overflow_ff_01: got %h c=%b id=%0d expected 00 c=1 id=3", rsp_sum, rsp_carry, rsp_id); end
    tick();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) set_op(i, 8'($urandom), 8'($urandom));
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, 4'(1 << (k % 4))); end
      if (k > 0) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4)) begin errors++; $display("FAIL rr_rsp_%0d: got v=%b id=%0d expected v=1 id=%0d", k, rsp_valid, rsp_id, (k - 1) % 4); end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (rsp_id !== 2'd0 || rsp_sum !== 8'(m_sum) || rsp_carry !== 1'(m_carry)) begin errors++; $display("FAIL rr_last: got id=%0d %h c=%b expected id=0 %h c=%0d", rsp_id, rsp_sum, rsp_carry, m_sum, m_carry); end
  endtask

  task automatic test_backpressure();
    int held_sum;
    held_sum = m_sum;
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 0000", k, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'(held_sum)) begin errors++; $display("FAIL bp_hold_%0d: got v=%b id=%0d %h expected v=1 id=0 %h", k, rsp_valid, rsp_id, rsp_sum, held_sum); end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'(m_sum)) begin errors++; $display("FAIL bp_release_rsp: got v=%b id=%0d %h expected v=1 id=1 %h", rsp_valid, rsp_id, rsp_sum, m_sum); end
  endtask

  task automatic test_reset_mid_stall();
    rsp_ready = 1'b0; req_valid = 4'hF;
    #1;
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL stall_pre: got v=%b ready=%b expected v=1 ready=0000", rsp_valid, req_ready); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_reset_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_reset_ptr: got %b expected 0001", req_ready); end
    req_valid = 4'h0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready_%0d: got %b expected %b", c, req_ready, exp_ready()); end
      checks++; if (rsp_valid !== m_valid || rsp_id !== 2'(m_id) || rsp_sum !== 8'(m_sum) || rsp_carry !== 1'(m_carry)) begin
        errors++;
        $display("FAIL rand_rsp_%0d: got v=%b id=%0d %h c=%b expected v=%b id=%0d %h c=%0d", c, rsp_valid, rsp_id, rsp_sum, rsp_carry, m_valid, m_id, m_sum, m_carry);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'h0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
